// File: rtl/aes_pkg.sv
// Shared constants, tables and GF(2^8) helpers for the AES-128 inverse core.
// Byte 0 of a 128-bit block sits in bits [127:120]; columns are 32-bit words.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEXP,
        S_ADDK,
        S_ROUND,
        S_FINAL
    } state_t;

    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    // sw is SubWord(RotWord(.)) of the appropriate word, supplied by the caller.
    function automatic logic [127:0] fwd_key_step(input logic [127:0] k,
                                                  input logic [31:0] sw,
                                                  input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sw ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] inv_key_step(input logic [127:0] k,
                                                  input logic [31:0] sw,
                                                  input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sw ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] i_st,
    input  logic [127:0] i_rk,
    input  logic         i_is_final,
    output logic [127:0] o_st
);

    logic [127:0] w_sr;
    logic [127:0] w_sb;
    logic [127:0] w_ak;

    assign w_sr = inv_shift_rows(i_st);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign w_sb[127-8*i -: 8] = INV_SBOX[w_sr[127-8*i -: 8]];
    end

    assign w_ak = w_sb ^ i_rk;
    assign o_st = i_is_final ? w_ak : inv_mix_columns(w_ak);

endmodule

// File: rtl/aes_inv_top.sv
// Iterative AES-128 decryptor: expands K0 up to K10, then walks the
// schedule back down while applying one inverse round per clock.
module aes_inv_top
    import aes_pkg::*;
(
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic         AES_busy,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    state_t       r_state, w_state_nx;
    logic [127:0] r_st, w_st_nx;
    logic [127:0] r_key, w_key_nx;
    logic [127:0] r_out, w_out_nx;
    logic [3:0]   r_rc, w_rc_nx;
    logic         r_busy, w_busy_nx;
    logic         r_valid, w_valid_nx;

    logic [31:0]  w_sw_in;
    logic [31:0]  w_sw;
    logic [7:0]   w_rcon;
    logic [127:0] w_key_fwd;
    logic [127:0] w_key_inv;
    logic [127:0] w_round;
    logic         w_is_final;

    // Forward and inverse key steps share the same four S-boxes.
    assign w_sw_in   = (r_state == S_KEXP) ? r_key[31:0]
                                           : r_key[31:0] ^ r_key[63:32];
    assign w_sw      = sub_word(rot_word(w_sw_in));
    assign w_rcon    = RCON[r_rc];
    assign w_key_fwd = fwd_key_step(r_key, w_sw, w_rcon);
    assign w_key_inv = inv_key_step(r_key, w_sw, w_rcon);

    assign w_is_final = (r_state == S_FINAL);

    aes_inv_round u_round (
        .i_st       (r_st),
        .i_rk       (r_key),
        .i_is_final (w_is_final),
        .o_st       (w_round)
    );

    always_comb begin
        w_state_nx = r_state;
        w_st_nx    = r_st;
        w_key_nx   = r_key;
        w_rc_nx    = r_rc;
        w_busy_nx  = r_busy;
        w_out_nx   = r_out;
        w_valid_nx = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (AES_en) begin
                    w_st_nx    = AES_data_in;
                    w_key_nx   = AES_key_in;
                    w_rc_nx    = 4'd1;
                    w_busy_nx  = 1'b1;
                    w_state_nx = S_KEXP;
                end
            end
            S_KEXP: begin
                w_key_nx = w_key_fwd;
                if (r_rc == NR) begin
                    w_state_nx = S_ADDK;
                end else begin
                    w_rc_nx = r_rc + 4'd1;
                end
            end
            S_ADDK: begin
                w_st_nx    = r_st ^ r_key;
                w_key_nx   = w_key_inv;
                w_rc_nx    = NR - 4'd1;
                w_state_nx = S_ROUND;
            end
            S_ROUND: begin
                w_st_nx  = w_round;
                w_key_nx = w_key_inv;
                w_rc_nx  = r_rc - 4'd1;
                if (r_rc == 4'd1) w_state_nx = S_FINAL;
            end
            S_FINAL: begin
                w_out_nx   = w_round;
                w_valid_nx = 1'b1;
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_state <= S_IDLE;
            r_st    <= '0;
            r_key   <= '0;
            r_out   <= '0;
            r_rc    <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_st    <= w_st_nx;
            r_key   <= w_key_nx;
            r_out   <= w_out_nx;
            r_rc    <= w_rc_nx;
            r_busy  <= w_busy_nx;
            r_valid <= w_valid_nx;
        end
    end

    assign AES_busy           = r_busy;
    assign AES_data_out       = r_out;
    assign AES_data_out_valid = r_valid;

endmodule
